// File: rtl/load_register_hist_pkg.sv
// Shared definitions for the load register with undo history.
// Holds the decoded operation type, the priority decode function and the
// modulo ring-step helper used by the history ring.
package load_register_hist_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_LOAD  = 2'd2,
    OP_UNDO  = 2'd3
  } op_e;

  // Priority decode: clear beats load beats undo. An undo with nothing in
  // the history decodes to OP_NONE so it produces neither a state change nor
  // a changed pulse.
  function automatic op_e decode_op(input logic clear, input logic load,
                                    input logic undo, input logic can_undo);
    op_e op;
    if (clear) begin
      op = OP_CLEAR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (undo && can_undo) begin
      op = OP_UNDO;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

  // Step a pointer up or down modulo depth; works for any depth, not only
  // powers of two.
  function automatic int ring_step(input int ptr, input int depth, input logic up);
    int r;
    if (up) begin
      if (ptr >= depth - 32'sd1) begin
        r = 32'sd0;
      end else begin
        r = ptr + 32'sd1;
      end
    end else begin
      if (ptr == 32'sd0) begin
        r = depth - 32'sd1;
      end else begin
        r = ptr - 32'sd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/load_register_hist_if.sv
// Bus interface for load_register_hist.
// master: switch/debounce side (drives value_in, load, undo, clear).
// slave : the register (drives value_out, valid, count, empty, full, changed).
interface load_register_hist_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] value_in;
  logic             load;
  logic             undo;
  logic             clear;
  logic [WIDTH-1:0] value_out;
  logic             valid;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             changed;

  modport master (
    output value_in, load, undo, clear,
    input  value_out, valid, count, empty, full, changed
  );

  modport slave (
    input  value_in, load, undo, clear,
    output value_out, valid, count, empty, full, changed
  );
endinterface

// File: rtl/load_register_hist_hist_ring.sv
// DEPTH x WIDTH ring LIFO holding previously displayed values.
// Ports: clk, rst (sync, active-high), flush (drop all entries), push/din
// (store newest, overwriting the oldest when full), pop (drop newest),
// dout (newest entry, combinational read), count/empty/full (registered).
module load_register_hist_hist_ring
  import load_register_hist_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    ptr_r;
  logic [CW-1:0]    count_r;
  logic             empty_r;
  logic             full_r;

  logic [PW-1:0]    next_ptr_s;
  logic [PW-1:0]    prev_ptr_s;
  logic [CW-1:0]    next_count_s;
  logic             wr_en_s;

  // Newest entry sits just below the write pointer.
  assign prev_ptr_s = PW'(ring_step(int'(ptr_r), DEPTH, 1'b0));
  assign dout       = mem_r[prev_ptr_s];

  // Next pointer/count; a full push keeps count at DEPTH and the write lands
  // on the oldest slot, which is exactly where ptr_r points when full.
  always_comb begin
    next_ptr_s   = ptr_r;
    next_count_s = count_r;
    wr_en_s      = 1'b0;
    if (flush) begin
      next_ptr_s   = {PW{1'b0}};
      next_count_s = {CW{1'b0}};
    end else if (push) begin
      wr_en_s    = 1'b1;
      next_ptr_s = PW'(ring_step(int'(ptr_r), DEPTH, 1'b1));
      if (count_r == DEPTH_C) begin
        next_count_s = count_r;
      end else begin
        next_count_s = count_r + CW'(1);
      end
    end else if (pop && (count_r != {CW{1'b0}})) begin
      next_ptr_s   = prev_ptr_s;
      next_count_s = count_r - CW'(1);
    end else begin
      next_ptr_s   = ptr_r;
      next_count_s = count_r;
    end
  end

  // Pointer, count and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r   <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      ptr_r   <= next_ptr_s;
      count_r <= next_count_s;
      empty_r <= (next_count_s == {CW{1'b0}});
      full_r  <= (next_count_s == DEPTH_C);
    end
  end

  // Entry storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[ptr_r] <= din;
    end
  end

  assign count = count_r;
  assign empty = empty_r;
  assign full  = full_r;

endmodule

// File: rtl/load_register_hist.sv
// Load register with undo history for one 7-segment operand display.
// Ports: clk, rst (sync, active-high), bus (slave modport): value_in, load,
// undo, clear in; value_out, valid, count, empty, full, changed out.
// Outputs are all registered and reflect an operation one cycle later.
module load_register_hist
  import load_register_hist_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  load_register_hist_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] value_r;
  logic             valid_r;
  logic             changed_r;

  op_e              op_s;
  logic             push_s;
  logic             pop_s;
  logic             flush_s;
  logic [WIDTH-1:0] ring_dout_s;
  logic [CW-1:0]    ring_count_s;
  logic             ring_empty_s;
  logic             ring_full_s;

  assign op_s    = decode_op(bus.clear, bus.load, bus.undo, !ring_empty_s);
  // Only a previously loaded value is worth saving; a blank display is not.
  assign push_s  = (op_s == OP_LOAD) && valid_r;
  assign pop_s   = (op_s == OP_UNDO);
  assign flush_s = (op_s == OP_CLEAR);

  load_register_hist_hist_ring #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (value_r),
    .dout  (ring_dout_s),
    .count (ring_count_s),
    .empty (ring_empty_s),
    .full  (ring_full_s)
  );

  // Displayed value, valid flag and the one-cycle changed pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r   <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      changed_r <= 1'b0;
    end else begin
      case (op_s)
        OP_CLEAR: begin
          value_r   <= {WIDTH{1'b0}};
          valid_r   <= 1'b0;
          changed_r <= 1'b1;
        end
        OP_LOAD: begin
          value_r   <= bus.value_in;
          valid_r   <= 1'b1;
          changed_r <= 1'b1;
        end
        OP_UNDO: begin
          value_r   <= ring_dout_s;
          changed_r <= 1'b1;
        end
        OP_NONE: begin
          changed_r <= 1'b0;
        end
        default: begin
          changed_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.value_out = value_r;
  assign bus.valid     = valid_r;
  assign bus.count     = ring_count_s;
  assign bus.empty     = ring_empty_s;
  assign bus.full      = ring_full_s;
  assign bus.changed   = changed_r;

endmodule

// File: doc/load_register_hist.md
# load_register_hist

Parametrised load register with an undo history for the game's operand/answer displays. The register holds a WIDTH-bit value that changes only on an explicit load, so switch movement does not reach the 7-segment displays until the player commits it. Each load saves the displayed value onto a DEPTH-entry history. An undo restores the previously loaded value, and a clear blanks the display. It sits between the switch/debounce logic and the 7-segment decoders, one instance per displayed operand.

## Interface
Parameters:
- WIDTH, default 4, bit width of the held value (≥1).
- DEPTH, default 4, number of history entries (≥1).

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Value_in  input  WIDTH  candidate value from the switches.
- Load  input  1  commit Value_in to Value_out.
- Undo  input  1  restore the most recent history entry.
- Clear  input  1  blank the display and flush the history.
- Value_out  output  WIDTH  held value, drives the display decoder.
- Valid  output  1  Value_out holds a loaded value; the display is blanked when 0.
- Count  output  $clog2(DEPTH+1)  number of history entries held.
- Empty  output  1  Count == 0.
- Full  output  1  Count == DEPTH.
- Changed  output  1  one-cycle pulse after any accepted operation.

## Operation
- One operation per cycle. Priority order: Reset > Clear > Load > Undo.
- Reset: Value_out=0, Valid=0, Count=0, Empty=1, Full=0, Changed=0. History contents are don't-care.
- Clear:
  - Value_out=0, Valid=0, Count=0.
  - Changed=1 next cycle, even if the block is already clear.
- Load:
  - If Valid=1, push the old Value_out onto the history. If Valid=0, nothing is pushed.
  - Value_out=Value_in, Valid=1.
  - If the history is full, the push overwrites the oldest entry and Count stays at DEPTH (ring behaviour).
  - A load is accepted even when Value_in equals Value_out.
- Undo:
  - If Count>0: Value_out = newest entry, Count−1, Valid remains 1.
  - If Count=0: ignored. No state change and no Changed pulse.
- Load and Undo asserted in the same cycle: Load wins and Undo is dropped.
- Changed is asserted on the cycle after any accepted Clear, Load or Undo. An ignored Undo does not assert it.
- Inputs are level-sampled every cycle, so the upstream logic must supply single-cycle pulses. A level held for N cycles performs N operations.

## Timing
- All outputs are registered. Value_out, Valid, Count, Empty, Full and Changed update on the same edge that samples the operation, and are visible in the following cycle.
- Latency from operation input to output is one cycle. There are no multi-cycle operations and no busy state.
- Reset applied mid-sequence takes effect at the next edge regardless of the other inputs.
- Count arithmetic:
  - Saturates at DEPTH on push and never wraps.
  - An undo decrements only from a nonzero value.
- History pointer:
  - A write pointer modulo DEPTH is incremented on push and decremented on pop.
  - Pop reads the entry at (ptr−1) mod DEPTH.
  - Wrap-around is required for DEPTH values that are not a power of two.

## Structure
- The shared package holds a typedef for the decoded operation (OP_NONE, OP_CLEAR, OP_LOAD, OP_UNDO) and the priority decode function.
- Sub-module hist_ring: a DEPTH×WIDTH ring LIFO.
  - Inputs: push, pop, din.
  - Outputs: dout (newest entry, combinational read), count, empty, full.
  - Overwrite-oldest on full push.
- The top level holds Value_out/Valid, the operation decode and the Changed register.

## Test plan
All scenarios use WIDTH=4, DEPTH=4.
1. Reset → Value_out=0, Valid=0, Count=0, Empty=1, Full=0, Changed=0.
2. Undo on an empty history, and a held-level input:
   - Undo with Count=0 → no state change, no Changed pulse.
   - Load=1 held for 3 cycles with Value_in=7 → 3 loads, Count=2.
3. Undo chain:
   - Load 3, 5, 9 → Value_out=9, Count=2.
   - Undo → 5; Undo → 3, Empty=1.
   - A third Undo → stays 3, no Changed pulse.
4. Overflow: Load 1,2,3,4,5,6 → Value_out=6, Count=4, Full=1. Undos then give 5,4,3,2; the next Undo is ignored.
5. Simultaneous operations:
   - Load=1 and Undo=1 with Value_in=A after loading 2 → Value_out=A, Count=1.
   - Clear with Load=1 → Value_out=0, Valid=0, Count=0, Changed=1.
6. Reset with Load=1 and Count=3 → all outputs return to their reset values, and the Load is lost.
